seg_display_arbiter: RTL and testbench

Shares the board's 8-digit seven-segment display between several 32-bit data sources (e.g. PC, ALU result, register-file probe, memory data). It sits in front of the seven-segment driver and feeds that driver's 32-bit data word. Ownership is granted round-robin with a minimum dwell time, so each requester stays readable on the display. A hold input freezes rotation.

---
 rtl/seg_display_arbiter_if.sv | 26 ++
 rtl/seg_display_arbiter.sv | 138 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// Bus between the data sources and the seven-segment display arbiter.
// The master side drives requests, source words and hold.
// The slave side (the arbiter) drives grant, owner, disp_valid and disp_data.
interface seg_display_arbiter_if #(
    parameter int NUM_SRC = 4
) ();
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]    req;
    logic [32*NUM_SRC-1:0] src_data;
    logic                  hold;
    logic [NUM_SRC-1:0]    grant;
    logic [SEL_W-1:0]      owner;
    logic                  disp_valid;
    logic [31:0]           disp_data;

    modport master (
        output req, src_data, hold,
        input  grant, owner, disp_valid, disp_data
    );

    modport slave (
        input  req, src_data, hold,
        output grant, owner, disp_valid, disp_data
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that shares the 8-digit seven-segment display among
// NUM_SRC 32-bit sources. An owner keeps the display for at least
// DWELL_CYCLES cycles while others wait. hold freezes the dwell-based rotation.
// If the owner drops its request, the display moves on at once.
module seg_display_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input logic                 clk,
    input logic                 reset,
    seg_display_arbiter_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned NSRC = NUM_SRC;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_RST   = SEL_W'(NUM_SRC - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        src_w [NUM_SRC];
    logic [NUM_SRC-1:0] owner_oh;
    logic [NUM_SRC-1:0] others;
    logic [NUM_SRC-1:0] switch_mask;
    logic               switch_en;
    logic [SEL_W-1:0]   win;

    // Searches the requests for the first asserted one, starting just after last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] mask,
                                                 input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            idx = (32'(last) + k) % NSRC;
            if (!found && mask[idx]) begin
                pick  = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Splits the packed source bus into one word per source.
    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_w[i] = bus.src_data[32*i +: 32];
        end
    end

    // Decides the next owner and dwell count, and loads the display word.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        switch_en   = 1'b0;
        switch_mask = '0;
        owner_oh    = '0;
        owner_oh[owner_q] = 1'b1;
        others      = bus.req & ~owner_oh;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    switch_en   = 1'b1;
                    switch_mask = bus.req;
                end
            end
            SHOW: begin
                if (!bus.req[owner_q]) begin
                    if (|others) begin
                        switch_en   = 1'b1;
                        switch_mask = others;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q == DWELL_LAST && !bus.hold && |others) begin
                    switch_en   = 1'b1;
                    switch_mask = others;
                end else begin
                    data_d = src_w[owner_q];
                    if (cnt_q != DWELL_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        win = rr_pick(switch_mask, last_q);
        if (switch_en) begin
            state_d       = SHOW;
            owner_d       = win;
            last_d        = win;
            grant_d       = '0;
            grant_d[win]  = 1'b1;
            data_d        = src_w[win];
            cnt_d         = '0;
        end
    end

    // Holds the arbiter state. Reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.owner      = owner_q;
    assign bus.disp_valid = (state_q == SHOW);
    assign bus.disp_data  = data_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with NUM_SRC=4 and DWELL_CYCLES=4.
// The reference model counts the cycles since each grant and picks winners
// round-robin over plain integer indices.
module tb_seg_display_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic reset;

    seg_display_arbiter_if #(.NUM_SRC(N)) bus ();

    seg_display_arbiter #(
        .NUM_SRC      (N),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          m_owner, m_last, m_held;
    bit          m_valid;
    logic [31:0] m_data;
    logic [38:0] exp_v;
    logic [38:0] act;

    assign act = {bus.grant, bus.owner, bus.disp_valid, bus.disp_data};

    function automatic int rr(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return last;
    endfunction

    task automatic model_give(input int w);
        m_owner = w;
        m_last  = w;
        m_valid = 1'b1;
        m_data  = bus.src_data[32*w +: 32];
        m_held  = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] others;
        if (reset) begin
            m_valid = 1'b0; m_owner = 0; m_last = N - 1; m_data = '0; m_held = 0;
        end else if (!m_valid) begin
            if (bus.req != 0) model_give(rr(bus.req, m_last));
        end else begin
            others = bus.req;
            others[m_owner] = 1'b0;
            if (!bus.req[m_owner]) begin
                if (others != 0) model_give(rr(others, m_last));
                else m_valid = 1'b0;
            end else if (m_held >= DW - 1 && !bus.hold && others != 0) begin
                model_give(rr(others, m_last));
            end else begin
                m_data = bus.src_data[32*m_owner +: 32];
                m_held++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        exp_v = {(m_valid ? 4'(1 << m_owner) : 4'b0000), 2'(m_owner), m_valid, m_data};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.hold = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 4'b1111;
        bus.src_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (act !== 39'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, act, 39'h0);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (act !== exp_v || bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", act, exp_v);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.src_data[95:64] = 32'hDEADBEEF;
        bus.req = 4'b0100;
        step();
        checks++;
        if (act !== {4'b0100, 2'd2, 1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_grant: got %h want %h", act, {4'b0100, 2'd2, 1'b1, 32'hDEADBEEF});
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL single_hold[%0d]: got %h want %h", i, act, exp_v);
            end
        end
        bus.src_data[95:64] = 32'h12345678;
        step();
        checks++;
        if (bus.disp_data !== 32'h12345678 || bus.owner !== 2'd2) begin
            errors++;
            $display("FAIL single_live: got %h want %h", bus.disp_data, 32'h12345678);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.req = 4'b1111;
        for (int c = 1; c <= 17; c++) begin
            step();
            checks++;
            if (bus.owner !== 2'(((c - 1) / DW) % N) || bus.grant !== 4'(1 << (((c - 1) / DW) % N))) begin
                errors++;
                $display("FAIL rotation_seq[%0d]: got owner %0d grant %b want owner %0d", c, bus.owner, bus.grant, ((c - 1) / DW) % N);
            end
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL rotation_model[%0d]: got %h want %h", c, act, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 5; c++) step();
        checks++;
        if (bus.owner !== 2'd1) begin
            errors++;
            $display("FAIL hold_setup: got %0d want %0d", bus.owner, 1);
        end
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.owner !== 2'd1 || act !== exp_v) begin
                errors++;
                $display("FAIL hold_freeze[%0d]: got %h want %h", i, act, exp_v);
            end
        end
        bus.hold = 1'b0;
        step();
        checks++;
        if (bus.owner !== 2'd2 || bus.grant !== 4'b0100) begin
            errors++;
            $display("FAIL hold_release: got owner %0d want %0d", bus.owner, 2);
        end
    endtask

    task automatic test_release();
        do_reset();
        bus.src_data[127:96] = 32'hCAFE0003;
        bus.req = 4'b1001;
        step();
        step();
        checks++;
        if (bus.owner !== 2'd0 || act !== exp_v) begin
            errors++;
            $display("FAIL release_setup: got %h want %h", act, exp_v);
        end
        bus.req = 4'b1000;
        step();
        checks++;
        if (act !== {4'b1000, 2'd3, 1'b1, 32'hCAFE0003}) begin
            errors++;
            $display("FAIL release_switch: got %h want %h", act, {4'b1000, 2'd3, 1'b1, 32'hCAFE0003});
        end
        bus.req = 4'b0000;
        bus.src_data[127:96] = 32'h0BADF00D;
        step();
        checks++;
        if (act !== {4'b0000, 2'd3, 1'b0, 32'hCAFE0003}) begin
            errors++;
            $display("FAIL release_idle: got %h want %h", act, {4'b0000, 2'd3, 1'b0, 32'hCAFE0003});
        end
    endtask

    task automatic test_midreset();
        do_reset();
        bus.req = 4'b1000;
        step();
        step();
        checks++;
        if (bus.owner !== 2'd3 || bus.disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: got owner %0d want %0d", bus.owner, 3);
        end
        bus.req = 4'b1010;
        reset = 1'b1;
        step();
        checks++;
        if (act !== 39'h0) begin
            errors++;
            $display("FAIL midreset_values: got %h want %h", act, 39'h0);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.grant !== 4'b0010 || bus.owner !== 2'd1 || act !== exp_v) begin
            errors++;
            $display("FAIL midreset_regrant: got %h want %h", act, exp_v);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) bus.req = 4'($urandom);
            bus.hold = ($urandom_range(4) == 0);
            bus.src_data = {$urandom, $urandom, $urandom, $urandom};
            reset = ($urandom_range(80) == 0);
            step();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, act, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.req = '0;
        bus.hold = 1'b0;
        bus.src_data = '0;
        m_owner = 0; m_last = N - 1; m_held = 0; m_valid = 1'b0; m_data = '0;
        exp_v = '0;
        test_reset();
        test_single();
        test_rotation();
        test_hold();
        test_release();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
